// File: rtl/vdf_pkg.sv
// Shared VDF definitions: default widths, controller state encoding and the
// squarer timing constants the controller and its bench depend on.
package vdf_pkg;

  localparam int unsigned VDF_MOD_LEN      = 128;
  localparam int unsigned VDF_T_WIDTH      = 32;

  // Modular squarer timing: pipeline depth and start-to-first-result latency.
  localparam int unsigned PIPELINE_DEPTH   = 10;
  localparam int unsigned SQ_FIRST_LATENCY = 11;

  typedef enum logic [1:0] {
    IDLE,
    START,
    RUN,
    DONE
  } vdf_ctrl_state_t;

endpackage

// File: rtl/vdf_iter_ctrl.sv
// VDF iteration sequencer: accepts a job (x, T), starts the modular squarer
// with x, counts T squarer result pulses and returns y = x^(2^T) mod N.
// A watchdog ends the job with res_err when the squarer stops delivering.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   job_valid/job_ready   job handshake; job_x base, job_t squaring count
//   sq_start, sq_in       one-cycle start pulse and base value to the squarer
//   sq_out, sq_valid      squarer result and its per-squaring valid pulse
//   res_valid/res_ready   result handshake; res_y value, res_err watchdog flag
//   busy, iter_count      not idle; squarings completed for the current job
module vdf_iter_ctrl
  import vdf_pkg::*;
#(
  parameter int unsigned MOD_LEN = VDF_MOD_LEN,
  parameter int unsigned T_WIDTH = VDF_T_WIDTH,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               job_valid,
  output logic               job_ready,
  input  logic [MOD_LEN-1:0] job_x,
  input  logic [T_WIDTH-1:0] job_t,
  output logic               sq_start,
  output logic [MOD_LEN-1:0] sq_in,
  input  logic [MOD_LEN-1:0] sq_out,
  input  logic               sq_valid,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [MOD_LEN-1:0] res_y,
  output logic               res_err,
  output logic               busy,
  output logic [T_WIDTH-1:0] iter_count
);

  localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  // The watchdog must outlast the squarer's first-result latency.
  if (TIMEOUT <= SQ_FIRST_LATENCY) begin : g_bad_timeout
    $error("vdf_iter_ctrl: TIMEOUT must exceed the squarer first-result latency");
  end

  vdf_ctrl_state_t    state;
  logic [T_WIDTH-1:0] t_q;
  logic [T_WIDTH-1:0] remaining;
  logic [WD_W-1:0]    wd;
  logic               job_rdy_q;

  // Ready is forced low while reset is held so it reads 1 in the first cycle after.
  assign job_ready = job_rdy_q & ~reset;

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      job_rdy_q  <= 1'b1;
      sq_start   <= 1'b0;
      sq_in      <= '0;
      t_q        <= '0;
      remaining  <= '0;
      wd         <= '0;
      res_valid  <= 1'b0;
      res_y      <= '0;
      res_err    <= 1'b0;
      busy       <= 1'b0;
      iter_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (job_valid) begin
            sq_in      <= job_x;
            t_q        <= job_t;
            iter_count <= '0;
            res_err    <= 1'b0;
            wd         <= '0;
            busy       <= 1'b1;
            job_rdy_q  <= 1'b0;
            if (job_t == '0) begin
              // Zero squarings: x passes through unreduced.
              res_y     <= job_x;
              res_valid <= 1'b1;
              state     <= DONE;
            end else begin
              sq_start <= 1'b1;
              state    <= START;
            end
          end
        end

        START: begin
          sq_start  <= 1'b0;
          remaining <= t_q;
          state     <= RUN;
        end

        RUN: begin
          if (sq_valid) begin
            remaining  <= remaining - T_WIDTH'(1);
            iter_count <= iter_count + T_WIDTH'(1);
            wd         <= '0;
            if (remaining == T_WIDTH'(1)) begin
              res_y     <= sq_out;
              res_valid <= 1'b1;
              state     <= DONE;
            end
          end else if (wd == WD_W'(TIMEOUT - 1)) begin
            // Squarer stalled: report an error with a zeroed result.
            res_err   <= 1'b1;
            res_y     <= '0;
            res_valid <= 1'b1;
            state     <= DONE;
          end else begin
            wd <= wd + WD_W'(1);
          end
        end

        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            job_rdy_q <= 1'b1;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
